// File: rtl/mod_stat_if.sv
// rtl/mod_stat_if.sv - sample stream and windowed-result handshake between mod_top and the stats monitor
interface mod_stat_if #(
  parameter int SUM_W = 35
);
  logic              i_start;
  logic              i_stop;
  logic              i_en;
  logic [31:0]       i_in;
  logic              i_ready;
  logic              o_valid;
  logic [SUM_W-1:0]  o_sum;
  logic [31:0]       o_min;
  logic [31:0]       o_max;
  logic [31:0]       o_mean;
  logic [7:0]        o_drop;
  logic              o_busy;

  modport master (
    output i_start, i_stop, i_en, i_in, i_ready,
    input  o_valid, o_sum, o_min, o_max, o_mean, o_drop, o_busy
  );

  modport slave (
    input  i_start, i_stop, i_en, i_in, i_ready,
    output o_valid, o_sum, o_min, o_max, o_mean, o_drop, o_busy
  );
endinterface

// File: rtl/mod_stat.sv
// rtl/mod_stat.sv - windowed sum/min/max/mean of the mod_top sample stream with a valid/ready result register
module mod_stat #(
  parameter int WIN      = 8,
  parameter int LOG2_WIN = 3,
  parameter int SUM_W    = 35
) (
  input  logic       clk,
  input  logic       rst_x,
  mod_stat_if.slave  s
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [LOG2_WIN-1:0] CNT_LAST = LOG2_WIN'(WIN - 1);

  state_t              state;
  logic [LOG2_WIN-1:0] cnt;
  logic [SUM_W-1:0]    acc_sum;
  logic [31:0]         acc_min;
  logic [31:0]         acc_max;

  logic                valid_q;
  logic                busy_q;
  logic [SUM_W-1:0]    sum_q;
  logic [31:0]         min_q;
  logic [31:0]         max_q;
  logic [31:0]         mean_q;
  logic [7:0]          drop_q;

  logic                accept;
  logic                complete;
  logic                xfer;
  logic                load;
  logic [SUM_W-1:0]    nxt_sum;
  logic [31:0]         nxt_min;
  logic [31:0]         nxt_max;
  logic [31:0]         nxt_mean;

  // nxt_* include the current sample so a completing window reports it
  always_comb begin
    accept   = (state == RUN) && s.i_en && !s.i_stop && !s.i_start;
    complete = accept && (cnt == CNT_LAST);
    xfer     = valid_q && s.i_ready;
    load     = complete && (!valid_q || s.i_ready);
    nxt_sum  = acc_sum + SUM_W'(s.i_in);
    nxt_min  = (s.i_in < acc_min) ? s.i_in : acc_min;
    nxt_max  = (s.i_in > acc_max) ? s.i_in : acc_max;
    nxt_mean = 32'(nxt_sum >> LOG2_WIN);
  end

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      state   <= IDLE;
      cnt     <= '0;
      acc_sum <= '0;
      acc_min <= 32'hFFFF_FFFF;
      acc_max <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      sum_q   <= '0;
      min_q   <= '0;
      max_q   <= '0;
      mean_q  <= '0;
      drop_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (s.i_start) begin
            state   <= RUN;
            busy_q  <= 1'b1;
            cnt     <= '0;
            acc_sum <= '0;
            acc_min <= 32'hFFFF_FFFF;
            acc_max <= '0;
          end
        end
        RUN: begin
          if (s.i_stop || s.i_start || complete) begin
            // stop, restart and window completion all leave the accumulators clean
            if (s.i_stop) begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
            cnt     <= '0;
            acc_sum <= '0;
            acc_min <= 32'hFFFF_FFFF;
            acc_max <= '0;
          end else if (accept) begin
            cnt     <= cnt + LOG2_WIN'(1);
            acc_sum <= nxt_sum;
            acc_min <= nxt_min;
            acc_max <= nxt_max;
          end
        end
        default: state <= IDLE;
      endcase

      if (load) begin
        valid_q <= 1'b1;
        sum_q   <= nxt_sum;
        min_q   <= nxt_min;
        max_q   <= nxt_max;
        mean_q  <= nxt_mean;
      end else if (xfer) begin
        valid_q <= 1'b0;
      end

      if (complete && !load && drop_q != 8'hFF) begin
        drop_q <= drop_q + 8'd1;
      end
    end
  end

  assign s.o_valid = valid_q;
  assign s.o_busy  = busy_q;
  assign s.o_sum   = sum_q;
  assign s.o_min   = min_q;
  assign s.o_max   = max_q;
  assign s.o_mean  = mean_q;
  assign s.o_drop  = drop_q;

endmodule

// File: tb/tb_mod_stat.sv
// tb/tb_mod_stat.sv - self-checking bench for mod_stat with WIN=4 and WIN=2 instances
module tb_mod_stat;

  logic clk = 1'b0;
  logic rst_x;
  always #5 clk = ~clk;

  mod_stat_if #(.SUM_W(34)) if4 ();
  mod_stat_if #(.SUM_W(33)) if2 ();

  mod_stat #(.WIN(4), .LOG2_WIN(2), .SUM_W(34)) u_dut4 (.clk(clk), .rst_x(rst_x), .s(if4.slave));
  mod_stat #(.WIN(2), .LOG2_WIN(1), .SUM_W(33)) u_dut2 (.clk(clk), .rst_x(rst_x), .s(if2.slave));

  int n_cmp = 0;
  int n_err = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if4.i_start = 0; if4.i_stop = 0; if4.i_en = 0; if4.i_in = 0;
    if2.i_start = 0; if2.i_stop = 0; if2.i_en = 0; if2.i_in = 0;
  endtask

  task automatic smp4(input logic [31:0] v);
    if4.i_en = 1; if4.i_in = v; tick(); if4.i_en = 0;
  endtask

  task automatic smp2(input logic [31:0] v);
    if2.i_en = 1; if2.i_in = v; tick(); if2.i_en = 0;
  endtask

  task automatic start4(); if4.i_start = 1; tick(); if4.i_start = 0; endtask
  task automatic stop4();  if4.i_stop  = 1; tick(); if4.i_stop  = 0; endtask
  task automatic start2(); if2.i_start = 1; tick(); if2.i_start = 0; endtask

  task automatic test_reset();
    rst_x = 0;
    for (int i = 0; i < 3; i++) begin
      if4.i_en = 1; if4.i_in = $urandom; if2.i_en = 1; if2.i_in = $urandom;
      tick();
    end
    rst_x = 1;
    for (int i = 0; i < 20; i++) begin
      if4.i_in = $urandom; if2.i_in = $urandom;
      tick();
      n_cmp++; if (if4.o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b want 0", if4.o_valid); end
      n_cmp++; if (if4.o_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %0b want 0", if4.o_busy); end
      n_cmp++; if (if4.o_sum !== 34'd0 || if4.o_min !== 32'd0 || if4.o_max !== 32'd0 || if4.o_mean !== 32'd0)
        begin n_err++; $display("FAIL reset_results got %0h/%0h/%0h/%0h want 0", if4.o_sum, if4.o_min, if4.o_max, if4.o_mean); end
      n_cmp++; if (if4.o_drop !== 8'd0) begin n_err++; $display("FAIL reset_drop got %0d want 0", if4.o_drop); end
      n_cmp++; if (if2.o_valid !== 1'b0 || if2.o_busy !== 1'b0)
        begin n_err++; $display("FAIL reset_w2 got valid %0b busy %0b want 0 0", if2.o_valid, if2.o_busy); end
    end
    idle_inputs();
  endtask

  task automatic test_basic();
    if4.i_ready = 1;
    start4();
    n_cmp++; if (if4.o_busy !== 1'b1) begin n_err++; $display("FAIL basic_busy got %0b want 1", if4.o_busy); end
    smp4(1); smp4(2); smp4(3);
    n_cmp++; if (if4.o_valid !== 1'b0) begin n_err++; $display("FAIL basic_early_valid got %0b want 0", if4.o_valid); end
    smp4(4);
    n_cmp++; if (if4.o_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid got %0b want 1", if4.o_valid); end
    n_cmp++; if (if4.o_sum !== 34'd10) begin n_err++; $display("FAIL basic_sum got %0d want 10", if4.o_sum); end
    n_cmp++; if (if4.o_min !== 32'd1) begin n_err++; $display("FAIL basic_min got %0d want 1", if4.o_min); end
    n_cmp++; if (if4.o_max !== 32'd4) begin n_err++; $display("FAIL basic_max got %0d want 4", if4.o_max); end
    n_cmp++; if (if4.o_mean !== 32'd2) begin n_err++; $display("FAIL basic_mean got %0d want 2", if4.o_mean); end
    tick();
    n_cmp++; if (if4.o_valid !== 1'b0) begin n_err++; $display("FAIL basic_valid_fall got %0b want 0", if4.o_valid); end
  endtask

  task automatic test_extremes();
    for (int i = 0; i < 4; i++) smp4(32'hFFFF_FFFF);
    n_cmp++; if (if4.o_sum !== 34'h3_FFFF_FFFC) begin n_err++; $display("FAIL ext_sum got %0h want 3fffffffc", if4.o_sum); end
    n_cmp++; if (if4.o_min !== 32'hFFFF_FFFF || if4.o_max !== 32'hFFFF_FFFF)
      begin n_err++; $display("FAIL ext_minmax got %0h/%0h want ffffffff", if4.o_min, if4.o_max); end
    n_cmp++; if (if4.o_mean !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL ext_mean got %0h want ffffffff", if4.o_mean); end
    tick();
  endtask

  task automatic test_backpressure();
    if4.i_ready = 0;
    for (int i = 1; i <= 12; i++) begin
      smp4(i);
      if (i >= 4) begin
        n_cmp++; if (if4.o_sum !== 34'd10 || if4.o_valid !== 1'b1)
          begin n_err++; $display("FAIL bp_hold got sum %0d valid %0b want 10 1", if4.o_sum, if4.o_valid); end
      end
    end
    n_cmp++; if (if4.o_drop !== 8'd2) begin n_err++; $display("FAIL bp_drop got %0d want 2", if4.o_drop); end
    if4.i_ready = 1;
    tick();
    n_cmp++; if (if4.o_valid !== 1'b0) begin n_err++; $display("FAIL bp_xfer got valid %0b want 0", if4.o_valid); end
    n_cmp++; if (if4.o_drop !== 8'd2) begin n_err++; $display("FAIL bp_drop_keep got %0d want 2", if4.o_drop); end
  endtask

  task automatic test_back_to_back();
    if2.i_ready = 1;
    start2();
    smp2(5); smp2(7);
    n_cmp++; if (if2.o_valid !== 1'b1 || if2.o_sum !== 33'd12)
      begin n_err++; $display("FAIL b2b_first got valid %0b sum %0d want 1 12", if2.o_valid, if2.o_sum); end
    n_cmp++; if (if2.o_min !== 32'd5 || if2.o_max !== 32'd7 || if2.o_mean !== 32'd6)
      begin n_err++; $display("FAIL b2b_first_mm got %0d/%0d/%0d want 5/7/6", if2.o_min, if2.o_max, if2.o_mean); end
    smp2(9);
    n_cmp++; if (if2.o_valid !== 1'b0) begin n_err++; $display("FAIL b2b_gap got valid %0b want 0", if2.o_valid); end
    smp2(11);
    n_cmp++; if (if2.o_valid !== 1'b1 || if2.o_sum !== 33'd20 || if2.o_mean !== 32'd10)
      begin n_err++; $display("FAIL b2b_second got valid %0b sum %0d mean %0d want 1 20 10", if2.o_valid, if2.o_sum, if2.o_mean); end
    tick();
    n_cmp++; if (if2.o_valid !== 1'b0) begin n_err++; $display("FAIL b2b_fall got valid %0b want 0", if2.o_valid); end
    n_cmp++; if (if2.o_drop !== 8'd0) begin n_err++; $display("FAIL b2b_drop got %0d want 0", if2.o_drop); end
  endtask

  task automatic test_drop_saturate();
    if2.i_ready = 0;
    for (int i = 0; i < 2 * 260; i++) smp2(3);
    n_cmp++; if (if2.o_drop !== 8'd255) begin n_err++; $display("FAIL sat_drop got %0d want 255", if2.o_drop); end
    n_cmp++; if (if2.o_sum !== 33'd6 || if2.o_valid !== 1'b1)
      begin n_err++; $display("FAIL sat_hold got sum %0d valid %0b want 6 1", if2.o_sum, if2.o_valid); end
    if2.i_ready = 1;
    tick();
    n_cmp++; if (if2.o_valid !== 1'b0) begin n_err++; $display("FAIL sat_xfer got valid %0b want 0", if2.o_valid); end
  endtask

  task automatic test_stop_restart();
    if4.i_ready = 1;
    start4();
    smp4(1); smp4(2);
    stop4();
    n_cmp++; if (if4.o_busy !== 1'b0) begin n_err++; $display("FAIL stop_busy got %0b want 0", if4.o_busy); end
    smp4(99);
    start4();
    n_cmp++; if (if4.o_busy !== 1'b1) begin n_err++; $display("FAIL restart_busy got %0b want 1", if4.o_busy); end
    smp4(10); smp4(20); smp4(30);
    n_cmp++; if (if4.o_valid !== 1'b0) begin n_err++; $display("FAIL restart_early got valid %0b want 0", if4.o_valid); end
    smp4(40);
    n_cmp++; if (if4.o_valid !== 1'b1 || if4.o_sum !== 34'd100)
      begin n_err++; $display("FAIL restart_sum got valid %0b sum %0d want 1 100", if4.o_valid, if4.o_sum); end
    n_cmp++; if (if4.o_min !== 32'd10 || if4.o_max !== 32'd40 || if4.o_mean !== 32'd25)
      begin n_err++; $display("FAIL restart_mm got %0d/%0d/%0d want 10/40/25", if4.o_min, if4.o_max, if4.o_mean); end
    tick();
  endtask

  task automatic test_reset_mid();
    if4.i_ready = 0;
    smp4(1); smp4(2); smp4(3); smp4(4);
    n_cmp++; if (if4.o_valid !== 1'b1) begin n_err++; $display("FAIL rmid_pending got valid %0b want 1", if4.o_valid); end
    smp4(5); smp4(6); smp4(7);
    #2 rst_x = 0;
    #1;
    n_cmp++; if (if4.o_valid !== 1'b0 || if4.o_busy !== 1'b0)
      begin n_err++; $display("FAIL rmid_async got valid %0b busy %0b want 0 0", if4.o_valid, if4.o_busy); end
    n_cmp++; if (if4.o_sum !== 34'd0 || if4.o_drop !== 8'd0)
      begin n_err++; $display("FAIL rmid_regs got sum %0d drop %0d want 0 0", if4.o_sum, if4.o_drop); end
    if4.i_ready = 1;
    tick();
    rst_x = 1;
    for (int i = 0; i < 6; i++) begin
      smp4(8 + i);
      n_cmp++; if (if4.o_valid !== 1'b0) begin n_err++; $display("FAIL rmid_noresult got valid %0b want 0", if4.o_valid); end
    end
  endtask

  task automatic test_random();
    bit               m_run;
    logic [31:0]      m_win[$];
    logic             m_valid;
    logic [33:0]      m_sum;
    logic [31:0]      m_min, m_max, m_mean;
    int               m_drop;
    logic             st, sp, en, rdy, ld;
    logic [31:0]      din;
    longint unsigned  s;
    rst_x = 0; idle_inputs(); if4.i_ready = 0;
    tick();
    rst_x = 1;
    m_run = 0; m_win.delete(); m_valid = 0; m_sum = 0; m_min = 0; m_max = 0; m_mean = 0; m_drop = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      st  = ($urandom_range(0, 29) == 0);
      sp  = ($urandom_range(0, 39) == 0);
      en  = ($urandom_range(0, 3) != 0);
      din = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : ($urandom_range(0, 1) ? $urandom : $urandom_range(0, 100));
      rdy = (cyc % 500 < 250) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 9) == 0);
      ld = 0;
      if (!m_run) begin
        if (st) begin m_run = 1; m_win.delete(); end
      end else if (sp) begin
        m_run = 0; m_win.delete();
      end else if (st) begin
        m_win.delete();
      end else if (en) begin
        m_win.push_back(din);
        if (m_win.size() == 4) begin
          if (!m_valid || rdy) begin
            s = 0; m_min = 32'hFFFF_FFFF; m_max = 0;
            foreach (m_win[k]) begin
              s += m_win[k];
              if (m_win[k] < m_min) m_min = m_win[k];
              if (m_win[k] > m_max) m_max = m_win[k];
            end
            m_sum = 34'(s); m_mean = 32'(s / 4); ld = 1;
          end else if (m_drop < 255) begin
            m_drop++;
          end
          m_win.delete();
        end
      end
      if (ld) m_valid = 1;
      else if (m_valid && rdy) m_valid = 0;
      if4.i_start = st; if4.i_stop = sp; if4.i_en = en; if4.i_in = din; if4.i_ready = rdy;
      tick();
      n_cmp++; if (if4.o_valid !== m_valid || if4.o_busy !== m_run)
        begin n_err++; $display("FAIL rand_ctrl cyc %0d got valid %0b busy %0b want %0b %0b", cyc, if4.o_valid, if4.o_busy, m_valid, m_run); end
      n_cmp++; if (if4.o_drop !== 8'(m_drop))
        begin n_err++; $display("FAIL rand_drop cyc %0d got %0d want %0d", cyc, if4.o_drop, m_drop); end
      n_cmp++; if (if4.o_sum !== m_sum || if4.o_min !== m_min || if4.o_max !== m_max || if4.o_mean !== m_mean)
        begin n_err++; $display("FAIL rand_result cyc %0d got %0h/%0h/%0h/%0h want %0h/%0h/%0h/%0h", cyc,
          if4.o_sum, if4.o_min, if4.o_max, if4.o_mean, m_sum, m_min, m_max, m_mean); end
    end
    idle_inputs();
  endtask

  initial begin
    rst_x = 0;
    idle_inputs();
    if4.i_ready = 0; if2.i_ready = 0;
    #1;
    n_cmp++; if (if4.o_valid !== 1'b0 || if4.o_drop !== 8'd0)
      begin n_err++; $display("FAIL reset_async got valid %0b drop %0d want 0 0", if4.o_valid, if4.o_drop); end
    test_reset();
    test_basic();
    test_extremes();
    test_backpressure();
    test_back_to_back();
    test_drop_saturate();
    test_stop_restart();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mod_stat.md
# mod_stat

Windowed statistics stage directly downstream of `mod_top`, consuming its 32-bit `o_out` stream. It accumulates fixed-size windows of unsigned samples and produces sum, min, max and mean per window. Results are presented through a valid/ready output register to the PLI-side monitor. Windows that complete while a result is still pending are counted as drops.

## Interface
- `WIN`, default 8: samples per window; power of two, 2..256.
- `LOG2_WIN`, default 3: log2(`WIN`); must match `WIN`.
- `SUM_W`, default 35: sum width; equals 32+`LOG2_WIN`.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_x`  in  1  asynchronous active-low reset.
- `i_start`  in  1  one-cycle pulse; IDLE -> RUN.
- `i_stop`  in  1  one-cycle pulse; RUN -> IDLE, discarding any partial window.
- `i_en`  in  1  sample qualifier for `i_in`.
- `i_in`  in  32  unsigned sample; connected to `mod_top.o_out`.
- `o_valid`  out  1  result register holds an unconsumed window.
- `i_ready`  in  1  consumer accepts the result.
- `o_sum`  out  `SUM_W`  window sum.
- `o_min`  out  32  window minimum.
- `o_max`  out  32  window maximum.
- `o_mean`  out  32  `o_sum >> LOG2_WIN`, truncated.
- `o_drop`  out  8  count of dropped windows; saturates at 255.
- `o_busy`  out  1  high in RUN.

## Operation
- FSM states: IDLE and RUN.
  - IDLE: samples ignored. `i_start` -> RUN, with the window counter at 0 and the accumulators cleared.
  - RUN: `i_stop` -> IDLE; the partial window is discarded and the counter cleared.
  - `i_stop` has priority over `i_start`. `i_start` in RUN restarts the window: counter 0, accumulators cleared, the current-cycle sample ignored.
  - `i_stop` in IDLE has no effect.
- Accumulation, on each RUN cycle with `i_en`=1 and no start/stop:
  - sum += `i_in`, zero-extended to `SUM_W`.
  - min = min(min, `i_in`); max = max(max, `i_in`).
  - counter increments.
- Clear values: sum 0, min 0xFFFFFFFF, max 0.
- Window completion: the WIN-th accepted sample completes the window.
  - The completed result includes that sample.
  - Accumulators restart clean, so the next accepted sample is the first of the new window.
  - The counter wraps to 0.
- Comparisons are unsigned. Sum cannot overflow at the given widths.
- Output register loads {sum, min, max, mean} when a window completes and either:
  - `o_valid`=0, or
  - `o_valid`=1 and `i_ready`=1 in the same cycle (back-to-back transfer).
- A completion with `o_valid`=1 and `i_ready`=0 is a drop:
  - the held result is unchanged;
  - `o_drop` increments, saturating at 255.
- `o_drop` clears only on reset.
- `o_valid` falls after a transfer cycle unless a new result loads in that same cycle.
- Result registers are stable while `o_valid`=1 and `i_ready`=0.
- A stop or restart does not affect a pending result.

## Timing
- Reset values:
  - state IDLE;
  - `o_valid`, `o_busy`, `o_sum`, `o_min`, `o_max`, `o_mean`, `o_drop` all 0;
  - internal sum 0, min 0xFFFFFFFF, max 0, counter 0.
- `o_busy` rises the cycle after the `i_start` edge and falls the cycle after the `i_stop` edge.
- Latency: WIN-th sample sampled at edge N -> `o_valid`=1 and results visible after edge N.
- Throughput: one sample per cycle. Consecutive windows with `i_ready` held 1 never drop.
- Transfer occurs on a rising edge with `o_valid`=1 and `i_ready`=1.
- `i_ready` may be asserted regardless of `o_valid`. `o_valid` does not depend combinationally on `i_ready`.
- Reset mid-window or mid-handshake:
  - asynchronous return to the reset values;
  - the pending result is lost;
  - no transfer completes in the reset cycle.

## Test plan
- Reset then idle: `rst_x` low for 3 cycles, `i_en`=1 with random `i_in`, no start -> all outputs 0, `o_busy`=0 for 20 cycles.
- Basic window (WIN=4), `i_ready`=1:
  - Stimulus: start, then samples 1,2,3,4.
  - Response: one cycle after the 4th sample, `o_valid`=1, `o_sum`=10, `o_min`=1, `o_max`=4, `o_mean`=2; `o_valid`=0 the next cycle.
- Extremes (WIN=4): samples 0xFFFFFFFF ×4 -> `o_sum`=0x3FFFFFFFC, `o_min`=`o_max`=`o_mean`=0xFFFFFFFF.
- Backpressure and drops (WIN=4):
  - Stimulus: `i_ready`=0, 12 consecutive samples 1..12.
  - Response: `o_sum` stays 10; `o_drop`=2.
  - Then `i_ready`=1 for one cycle -> transfer; `o_valid` falls.
- Back-to-back (WIN=2), `i_ready`=1, samples 5,7,9,11:
  - results sum 12 then 20;
  - `o_valid` pulses one cycle each;
  - `o_drop`=0.
- Stop and restart (WIN=4):
  - Stimulus: samples 1,2; `i_stop`; `i_start`; samples 10,20,30,40.
  - Response: sum 100, min 10, max 40.
  - A reset asserted after the 3rd sample leaves `o_valid`=0 and no result appears.
